// File: rtl/ha_seq_adder_pkg.sv
// ha_seq_adder_pkg: controller state encoding and default operand width
package ha_seq_adder_pkg;
   localparam int DEF_WIDTH = 8;
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      H1   = 3'd1,
      H2   = 3'd2,
      FIN  = 3'd3,
      DONE = 3'd4
   } state_e;
endpackage

// File: rtl/ha_seq_adder_ha.sv
// ha_seq_adder_ha: registered half-adder cell shared by the serial adder (1-cycle latency)
module ha_seq_adder_ha (
   input  logic clk,
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);
   always_ff @(posedge clk) begin
      sum   <= a ^ b;
      carry <= a & b;
   end
endmodule

// File: rtl/ha_seq_adder.sv
// ha_seq_adder: bit-serial adder time-sharing one external registered half-adder.
// HA_SEQ_ADDER_SUB_EN adds in_sub (A-B via inverted B and carry-in 1).
module ha_seq_adder
   import ha_seq_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
`ifdef HA_SEQ_ADDER_SUB_EN
   input  logic             in_sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy,
   output logic             ha_a,
   output logic             ha_b,
   input  logic             ha_sum,
   input  logic             ha_carry
);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   state_e           state_q;
   logic [IW-1:0]    idx_q;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             c_q, g1_q, cout_q, valid_q;
   logic [WIDTH-1:0] b_d;
   logic             c_d;

`ifdef HA_SEQ_ADDER_SUB_EN
   assign b_d = in_sub ? ~in_b : in_b;
   assign c_d = in_sub;
`else
   assign b_d = in_b;
   assign c_d = 1'b0;
`endif

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = valid_q;
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;

   // H1 feeds the operand bits; H2 folds the running carry into the partial sum
   always_comb begin
      ha_a = (state_q == H1) ? a_q[idx_q] : (state_q == H2) ? ha_sum : 1'b0;
      ha_b = (state_q == H1) ? b_q[idx_q] : (state_q == H2) ? c_q : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         c_q     <= 1'b0;
         g1_q    <= 1'b0;
         cout_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               a_q     <= in_a;
               b_q     <= b_d;
               idx_q   <= '0;
               c_q     <= c_d;
               state_q <= H1;
            end
            H1: begin
               if (idx_q != '0) begin
                  sum_q[idx_q - 1'b1] <= ha_sum;
                  c_q                 <= g1_q | ha_carry;
               end
               state_q <= H2;
            end
            H2: begin
               g1_q <= ha_carry;
               if (idx_q == LAST) state_q <= FIN;
               else begin
                  idx_q   <= idx_q + 1'b1;
                  state_q <= H1;
               end
            end
            FIN: begin
               sum_q[WIDTH-1] <= ha_sum;
               cout_q         <= g1_q | ha_carry;
               valid_q        <= 1'b1;
               state_q        <= DONE;
            end
            DONE: if (out_ready) begin
               valid_q <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ha_seq_adder.sv
// tb_ha_seq_adder: randomized and directed checks of ha_seq_adder against an arithmetic model
module tb_ha_seq_adder;
   logic       clk = 1'b0;
   logic       rst_n, in_valid, in_ready, out_valid, out_ready, out_cout, busy;
   logic       ha_a, ha_b, ha_sum, ha_carry;
   logic [7:0] in_a, in_b, out_sum;
`ifdef HA_SEQ_ADDER_SUB_EN
   logic       in_sub;
`endif
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ha_seq_adder #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b),
`ifdef HA_SEQ_ADDER_SUB_EN
      .in_sub(in_sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
      .busy(busy), .ha_a(ha_a), .ha_b(ha_b), .ha_sum(ha_sum), .ha_carry(ha_carry)
   );

   ha_seq_adder_ha u_ha (.clk(clk), .a(ha_a), .b(ha_b), .sum(ha_sum), .carry(ha_carry));

   // Called at a negedge; returns the result and cycles from accept edge to out_valid
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int bp,
                         output logic [7:0] s, output logic co, output int lat);
      int k = 0;
      while (!in_ready && k < 100) begin @(negedge clk); k++; end
      in_valid = 1'b1; in_a = a; in_b = b;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
      s = out_sum; co = out_cout;
      repeat (bp) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
`ifdef HA_SEQ_ADDER_SUB_EN
      in_sub = 1'b0;
`endif
      repeat (3) @(negedge clk);
      vectors++;
      if ({out_valid, out_cout, busy, in_ready} !== 4'b0001) begin
         miscompares++;
         $display("FAIL reset_flags got %b want 0001", {out_valid, out_cout, busy, in_ready});
      end
      vectors++;
      if (out_sum !== 8'h00) begin
         miscompares++; $display("FAIL reset_sum got %h want 00", out_sum);
      end
      vectors++;
      if ({ha_a, ha_b} !== 2'b00) begin
         miscompares++; $display("FAIL reset_ha got %b want 00", {ha_a, ha_b});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] s; logic co; int lat;
      run_op(8'h00, 8'h00, 0, s, co, lat);
      vectors++;
      if ({co, s} !== 9'h000) begin
         miscompares++; $display("FAIL zero_add got %b_%h want 0_00", co, s);
      end
      vectors++;
      if (lat !== 17) begin
         miscompares++; $display("FAIL latency got %0d want 17", lat);
      end
      run_op(8'hFF, 8'h01, 2, s, co, lat);
      vectors++;
      if ({co, s} !== 9'h100) begin
         miscompares++; $display("FAIL ripple got %b_%h want 1_00", co, s);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h5A;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
      vectors++;
      if ({out_cout, out_sum} !== 9'h0FF) begin
         miscompares++; $display("FAIL b2b_first got %b_%h want 0_ff", out_cout, out_sum);
      end
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL b2b_idle got in_ready=%b want 1", in_ready);
      end
      in_valid = 1'b1; in_a = 8'h80; in_b = 8'h80;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
      vectors++;
      if ({out_cout, out_sum} !== 9'h100 || lat !== 17) begin
         miscompares++;
         $display("FAIL b2b_second got %b_%h lat %0d want 1_00 lat 17", out_cout, out_sum, lat);
      end
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int lat;
      in_valid = 1'b1; in_a = 8'h3C; in_b = 8'h0F;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk); lat++;
         in_valid = (i >= 3 && i < 7); in_a = 8'hFF; in_b = 8'hFF;
      end
      vectors++;
      if ({busy, in_ready} !== 2'b10) begin
         miscompares++; $display("FAIL busy_flags got %b want 10", {busy, in_ready});
      end
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
      vectors++;
      if (lat !== 17) begin
         miscompares++; $display("FAIL bp_latency got %0d want 17", lat);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if ({out_valid, out_cout, out_sum} !== 10'h24B) begin
            miscompares++;
            $display("FAIL hold_done got v=%b %b_%h want v=1 0_4b", out_valid, out_cout, out_sum);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      vectors++;
      if ({out_valid, in_ready} !== 2'b01) begin
         miscompares++; $display("FAIL release got %b want 01", {out_valid, in_ready});
      end
   endtask

   task automatic test_abort();
      logic seen = 1'b0;
      in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({out_valid, out_cout, busy, in_ready, ha_a, ha_b} !== 6'b000100) begin
         miscompares++;
         $display("FAIL abort_flags got %b want 000100", {out_valid, out_cout, busy, in_ready, ha_a, ha_b});
      end
      vectors++;
      if (out_sum !== 8'h00) begin
         miscompares++; $display("FAIL abort_sum got %h want 00", out_sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++; $display("FAIL abort_no_result got out_valid seen=%b want 0", seen);
      end
   endtask

`ifdef HA_SEQ_ADDER_SUB_EN
   task automatic test_sub();
      logic [7:0] s; logic co; int lat;
      in_sub = 1'b1;
      run_op(8'h05, 8'h07, 0, s, co, lat);
      vectors++;
      if ({co, s} !== 9'h0FE || lat !== 17) begin
         miscompares++; $display("FAIL sub_borrow got %b_%h lat %0d want 0_fe lat 17", co, s, lat);
      end
      run_op(8'h07, 8'h05, 1, s, co, lat);
      vectors++;
      if ({co, s} !== 9'h102) begin
         miscompares++; $display("FAIL sub_noborrow got %b_%h want 1_02", co, s);
      end
      in_sub = 1'b0;
   endtask
`endif

   task automatic test_random();
      logic [7:0] a, b, s, es; logic co, ec, sb; int lat;
      for (int n = 0; n < 1000; n++) begin
         a = 8'($urandom); b = 8'($urandom); sb = 1'b0;
`ifdef HA_SEQ_ADDER_SUB_EN
         sb = 1'($urandom); in_sub = sb;
`endif
         if (sb) begin
            es = 8'((int'(a) - int'(b)) & 255); ec = (a >= b);
         end else begin
            es = 8'((int'(a) + int'(b)) & 255); ec = (int'(a) + int'(b)) > 255;
         end
         run_op(a, b, int'($urandom_range(0, 3)), s, co, lat);
         vectors++;
         if ({co, s} !== {ec, es} || lat !== 17) begin
            miscompares++;
            $display("FAIL random a=%h b=%h sub=%b got %b_%h lat %0d want %b_%h lat 17",
                     a, b, sb, co, s, lat, ec, es);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_abort();
`ifdef HA_SEQ_ADDER_SUB_EN
      test_sub();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
